// File: rtl/serial_alu_seq_if.sv
// Request/response bundle between a client and the bit-serial ALU sequencer.
interface serial_alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       func;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             ovf;
  logic             zero;

  modport master (
    output start, func, opa, opb,
    input  busy, done, err, y, carry, ovf, zero
  );

  modport slave (
    input  start, func, opa, opb,
    output busy, done, err, y, carry, ovf, zero
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Drives a 1-bit ALU slice LSB-first across a WIDTH-bit operation and
// assembles the result and flags, announced by a one-cycle done pulse.
module serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_alu_seq_if.slave   bus,
  output logic              s_a,
  output logic              s_b,
  output logic              s_ainvert,
  output logic              s_binvert,
  output logic              s_carryin,
  output logic [1:0]        s_op,
  input  logic              s_result,
  input  logic              s_cout
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb, r_res, r_y;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_arith, r_ainv, r_binv;
  logic [1:0]       r_op;
  logic             r_carry, r_ovf, r_zero, r_err;
  logic             w_accept, w_reject, w_last;
  logic [WIDTH-1:0] w_res_next;
  logic             w_ainv, w_binv, w_cin, w_arith;
  logic [1:0]       w_op;

  always_comb begin
    w_op = 2'd0; w_ainv = 1'b0; w_binv = 1'b0; w_cin = 1'b0; w_arith = 1'b0;
    case (bus.func)
      3'd1: w_op = 2'd1;
      3'd2: begin w_op = 2'd2; w_arith = 1'b1; end
      3'd3: begin w_op = 2'd2; w_binv = 1'b1; w_cin = 1'b1; w_arith = 1'b1; end
      3'd4: begin w_ainv = 1'b1; w_binv = 1'b1; end
      3'd5: begin w_op = 2'd1; w_ainv = 1'b1; w_binv = 1'b1; end
      default: ;
    endcase
  end

  assign w_accept   = (r_state == ST_IDLE) && bus.start && (bus.func <= 3'd5);
  assign w_reject   = (r_state == ST_IDLE) && bus.start && (bus.func > 3'd5);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = {s_result, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_RUN;
      ST_RUN:  if (w_last)   w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa <= '0; r_sb <= '0; r_res <= '0; r_y <= '0; r_cnt <= '0;
      r_c <= 1'b0; r_arith <= 1'b0; r_ainv <= 1'b0; r_binv <= 1'b0; r_op <= 2'd0;
      r_carry <= 1'b0; r_ovf <= 1'b0; r_zero <= 1'b0; r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_sa    <= bus.opa;
        r_sb    <= bus.opb;
        r_op    <= w_op;
        r_ainv  <= w_ainv;
        r_binv  <= w_binv;
        r_arith <= w_arith;
        r_c     <= w_cin;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_res <= w_res_next;
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_cnt <= r_cnt + 1'b1;
        if (r_arith) r_c <= s_cout;
        // r_c still holds the carry into the MSB during the last bit
        if (w_last) begin
          r_y     <= w_res_next;
          r_carry <= r_arith & s_cout;
          r_ovf   <= r_arith & (r_c ^ s_cout);
          r_zero  <= (w_res_next == '0);
        end
      end
    end
  end

  always_comb begin
    s_a = 1'b0; s_b = 1'b0; s_ainvert = 1'b0; s_binvert = 1'b0;
    s_carryin = 1'b0; s_op = 2'd0;
    bus.busy = 1'b0; bus.done = 1'b0;
    case (r_state)
      ST_RUN: begin
        s_a       = r_sa[0];
        s_b       = r_sb[0];
        s_ainvert = r_ainv;
        s_binvert = r_binv;
        s_carryin = r_c;
        s_op      = r_op;
        bus.busy  = 1'b1;
      end
      ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.err   = r_err;
  assign bus.y     = r_y;
  assign bus.carry = r_carry;
  assign bus.ovf   = r_ovf;
  assign bus.zero  = r_zero;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq wired to a behavioural 1-bit ALU slice, checked
// against a word-level arithmetic model of each operation.
module tb_serial_alu_seq;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_alu_seq_if #(.WIDTH(W)) bus();

  logic       s_a, s_b, s_ainvert, s_binvert, s_carryin, s_result, s_cout;
  logic [1:0] s_op;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_ainvert (s_ainvert),
    .s_binvert (s_binvert),
    .s_carryin (s_carryin),
    .s_op      (s_op),
    .s_result  (s_result),
    .s_cout    (s_cout)
  );

  // 1-bit ALU slice: optional operand inversion, then AND / OR / full-add
  logic w_ea, w_eb;
  always_comb begin
    w_ea   = s_a ^ s_ainvert;
    w_eb   = s_b ^ s_binvert;
    s_cout = (w_ea & w_eb) | (w_ea & s_carryin) | (w_eb & s_carryin);
    case (s_op)
      2'd0:    s_result = w_ea & w_eb;
      2'd1:    s_result = w_ea | w_eb;
      2'd2:    s_result = w_ea ^ w_eb ^ s_carryin;
      default: s_result = 1'b0;
    endcase
  end

  int errors = 0;
  int checks = 0;
  int n_done = 0;

  logic [7:0] held_y, pend_y;
  logic       held_c, held_v, held_z, pend_c, pend_v, pend_z, pend_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] y, output logic c, output logic v);
    logic [8:0] s;
    logic [7:0] bb;
    y = 8'h00; c = 1'b0; v = 1'b0;
    case (f)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd4: y = ~(a | b);
      3'd5: y = ~(a & b);
      3'd2, 3'd3: begin
        bb = (f == 3'd3) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + ((f == 3'd3) ? 9'd1 : 9'd0);
        y  = s[7:0];
        c  = s[8];
        v  = (a[7] == bb[7]) && (y[7] != a[7]);
      end
      default: ;
    endcase
  endfunction

  // Per-cycle comparison of held results, done events and idle slice drive
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        n_done++;
        chk("done_expected", {31'd0, pend_valid}, 32'd1);
        held_y = pend_y; held_c = pend_c; held_v = pend_v; held_z = pend_z;
        pend_valid = 1'b0;
      end
      chk("y", {24'd0, bus.y}, {24'd0, held_y});
      chk("flags", {29'd0, bus.carry, bus.ovf, bus.zero}, {29'd0, held_c, held_v, held_z});
      if (!bus.busy)
        chk("slice_idle", {25'd0, s_a, s_b, s_ainvert, s_binvert, s_carryin, s_op}, 32'd0);
    end
  end

  task automatic set_pending(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ey;
    logic ec, ev;
    model(f, a, b, ey, ec, ev);
    pend_y = ey; pend_c = ec; pend_v = ev; pend_z = (ey == 8'h00); pend_valid = 1'b1;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    int n;
    bus.func = f; bus.opa = a; bus.opb = b;
    if (f <= 3'd5) set_pending(f, a, b);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.func  = 3'($urandom);
    bus.opa   = 8'($urandom);
    bus.opb   = 8'($urandom);
    n = 1;
    if (f > 3'd5) begin
      chk("err_pulse", {31'd0, bus.err}, 32'd1);
      chk("err_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      chk("err_clear", {31'd0, bus.err}, 32'd0);
      chk("err_idle", {31'd0, bus.busy}, 32'd0);
      return;
    end
    chk("busy_rise", {31'd0, bus.busy}, 32'd1);
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, W + 1);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("busy_fall", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int d0, n;
    bus.start = 1'b0; bus.func = 3'd0; bus.opa = 8'h00; bus.opb = 8'h00;
    held_y = 8'h00; held_c = 1'b0; held_v = 1'b0; held_z = 1'b0;
    pend_y = 8'h00; pend_c = 1'b0; pend_v = 1'b0; pend_z = 1'b0; pend_valid = 1'b0;
    rst = 1'b1;
    #12;
    chk("reset_outputs", {11'd0, bus.y, bus.carry, bus.ovf, bus.zero, bus.done, bus.err,
        bus.busy, s_a, s_b, s_ainvert, s_binvert, s_carryin, s_op}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd2, 8'h7F, 8'h01);
    chk("add_lit", {20'd0, bus.y, bus.carry, bus.ovf, bus.zero, 1'b0}, {20'd0, 8'h80, 4'b0100});
    run_op(3'd3, 8'h05, 8'h05);
    chk("sub_eq_lit", {20'd0, bus.y, bus.carry, bus.ovf, bus.zero, 1'b0}, {20'd0, 8'h00, 4'b1010});
    run_op(3'd3, 8'h03, 8'h05);
    chk("sub_neg_lit", {23'd0, bus.y, bus.carry}, {23'd0, 8'hFE, 1'b0});
    run_op(3'd1, 8'hA0, 8'h05);
    chk("or_lit", {21'd0, bus.y, bus.carry, bus.ovf, bus.zero}, {21'd0, 8'hA5, 3'b000});
    run_op(3'd0, 8'hF0, 8'h3C);
    chk("and_lit", {21'd0, bus.y, bus.carry, bus.ovf, bus.zero}, {21'd0, 8'h30, 3'b000});
    run_op(3'd4, 8'hF0, 8'h0F);
    chk("nor_lit", {21'd0, bus.y, bus.carry, bus.ovf, bus.zero}, {21'd0, 8'h00, 3'b001});
    run_op(3'd5, 8'hFF, 8'hFF);
    chk("nand_lit", {21'd0, bus.y, bus.carry, bus.ovf, bus.zero}, {21'd0, 8'h00, 3'b001});
    run_op(3'd6, 8'h12, 8'h34);
    chk("err_keeps_y", {24'd0, bus.y}, 32'h00);

    // second start pulsed mid-operation must be ignored
    d0 = n_done;
    bus.func = 3'd2; bus.opa = 8'h12; bus.opb = 8'h34;
    set_pending(3'd2, 8'h12, 8'h34);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.func = 3'd1; bus.opa = 8'hFF; bus.opb = 8'h00; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("no_err_in_run", {31'd0, bus.err}, 32'd0);
    n = 0;
    while (!bus.done && n < 40) begin @(posedge clk); #1; n++; end
    chk("ignored_start_y", {24'd0, bus.y}, 32'h46);
    repeat (4) begin @(posedge clk); #1; end
    chk("single_done", n_done - d0, 32'd1);
    chk("idle_after", {31'd0, bus.busy}, 32'd0);

    // asynchronous reset after three bits of an ADD
    d0 = n_done;
    bus.func = 3'd2; bus.opa = 8'h55; bus.opb = 8'h22;
    set_pending(3'd2, 8'h55, 8'h22);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    pend_valid = 1'b0;
    held_y = 8'h00; held_c = 1'b0; held_v = 1'b0; held_z = 1'b0;
    #1;
    chk("abort_outputs", {11'd0, bus.y, bus.carry, bus.ovf, bus.zero, bus.done, bus.err,
        bus.busy, s_a, s_b, s_ainvert, s_binvert, s_carryin, s_op}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    chk("abort_no_done", n_done - d0, 32'd0);
    run_op(3'd2, 8'h01, 8'h01);
    chk("post_reset_add", {24'd0, bus.y}, 32'h02);

    for (int k = 0; k < 60; k++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
